// File: rtl/lsu_controller.sv
// Load/store sequencer: req/ack to data memory, byte enables, load extension. Optional LSU_MISALIGN_TRAP_EN.
// Latency: 3 cycles minimum (IDLE, ACCESS with same-cycle ack, DONE); stall held until the access completes or times out.
module lsu_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        wb_en,
    output logic [31:0] ld_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic               we_q;
    logic               to_q;
    logic               is_load, is_store, mem_op, cnt_last;
    logic [1:0]         off_al;
    logic [3:0]         be_nxt;
    logic [31:0]        wdat_nxt;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        ld_ext;
    logic               mis_op;
`ifdef LSU_MISALIGN_TRAP_EN
    logic               mis_q;
`endif

    assign is_load  = (opcode == 7'b0000011) &&
                      (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign is_store = (opcode == 7'b0100011) && (funct3 inside {3'b000, 3'b001, 3'b010});
    assign mem_op   = valid && (is_load || is_store);
    assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_op = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign mis_op = 1'b0;
`endif

    // Misaligned halves/words snap to lane 0 of their half/word.
    always_comb begin
        off_al   = 2'b00;
        be_nxt   = 4'b1111;
        wdat_nxt = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                off_al   = addr[1:0];
                be_nxt   = 4'b0001 << addr[1:0];
                wdat_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                off_al   = {addr[1], 1'b0};
                be_nxt   = 4'b0011 << {addr[1], 1'b0};
                wdat_nxt = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
    assign rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_ext = mem_rdata;
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_op) begin
                    stall     = 1'b1;
                    state_nxt = mis_op ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem_ack || cnt_last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req = (state == ACCESS);
    assign err     = (state == DONE) && to_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (state == DONE) && mis_q;
    assign wb_en    = (state == DONE) && !we_q && !to_q && !mis_q;
`else
    assign misalign = 1'b0;
    assign wb_en    = (state == DONE) && !we_q && !to_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            to_q      <= 1'b0;
            ld_data   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        funct3_q <= funct3;
                        off_q    <= off_al;
                        we_q     <= is_store;
                        to_q     <= 1'b0;
                        cnt      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_q    <= mis_op;
`endif
                        // A trapped access never reaches the bus, so the port keeps its last value.
                        if (!mis_op) begin
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_nxt;
                            mem_wdata <= wdat_nxt;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!we_q)
                            ld_data <= ld_ext;
                    end else if (cnt_last) begin
                        to_q    <= 1'b1;
                        ld_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Sequences load/store instructions to an external data memory over a req/ack handshake.
- Stalls the core until each access completes.
- Generates byte enables and lane-aligned write data; extracts and sign/zero-extends load data.
- Sits between the decode/ALU stage (effective address from ALU ADD) and the data memory port; the register file writes back on wb_en.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ack before the access is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid  in  1  instruction in execute stage is valid
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- addr  in  32  effective address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/pipeline this cycle
- wb_en  out  1  one-cycle pulse; write ld_data to rd
- ld_data  out  32  extended load result
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word
- mem_ack  in  1  access complete; rdata valid this cycle
- err  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse on misaligned access (see Optional Feature)

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0: stall, wb_en, ld_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata, err, misalign. Reset mid-access drops mem_req the next cycle; the outstanding ack is ignored.
- mem_op: valid=1 and either
  - opcode 0000011 with funct3 in {000,001,010,100,101}, or
  - opcode 0100011 with funct3 in {000,001,010}.
  - Other funct3 values are not memory ops: no stall, no request.
- States IDLE, ACCESS, DONE.
- IDLE:
  - On mem_op, go to ACCESS next cycle and register addr, wdata, funct3 and we.
  - stall is combinationally 1 in the same cycle.
- ACCESS:
  - mem_req=1, stall=1, and all mem_* outputs are held stable until ack.
  - mem_ack=1: capture mem_rdata, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: err=1 for 1 cycle, ld_data=0, go to DONE without wb_en.
  - Counter clears on entry to ACCESS.
- DONE:
  - stall=0. wb_en=1 for loads only (not after timeout). Return to IDLE.
  - The core advances this cycle, so the next instruction is seen in IDLE the following cycle.
  - Minimum load/store latency with same-cycle ack is 3 cycles of stall-gated occupancy: stall high in IDLE and ACCESS, low in DONE.
- Byte enables, with o = addr[1:0]:
  - SB: be = 4'b0001<<o, wdata[7:0] replicated to all 4 lanes.
  - SH: be = 4'b0011<<{o[1],1'b0}, wdata[15:0] replicated to both halves.
  - SW: be = 4'b1111.
- Load extraction: byte/half selected by o (same lanes as above).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word.
  - ld_data is held until the next load capture.
- Misaligned (LH/LHU/SH with o[0]=1; LW/SW with o!=0), without the feature: low address bits are forced to lane 0 of the selected half/word and the access proceeds normally.
- mem_ack while not in ACCESS is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned mem_op issues no mem_req. IDLE goes directly to DONE; misalign=1 for 1 cycle in DONE; wb_en suppressed; stall high for exactly 1 cycle.
- Undefined: misalign is tied 0 and misaligned accesses are forced-aligned as above.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, ack 2 cycles after req -> mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF, mem_we=1, stall high 4 cycles, no wb_en.
- SB addr=0x103 wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x102, mem_rdata=0x12F03456, same-cycle ack -> ld_data=0xFFFFFFF0, wb_en 1 pulse. LBU at the same address -> 0x000000F0. LHU addr=0x102 -> 0x000012F0.
- LW with mem_ack never asserted, TIMEOUT_CYCLES=4 -> err pulse after 4 ACCESS cycles, no wb_en, stall released, mem_req low next cycle.
- rst asserted during ACCESS, then a late mem_ack -> all outputs 0, state IDLE, no wb_en.
- LW addr=0x101 -> with LSU_MISALIGN_TRAP_EN: no mem_req, misalign pulse, stall 1 cycle. Without it: mem_addr=0x100, ld_data = full word, wb_en pulse.
